// File: rtl/piso_serial_tx_if.sv
// Word-load handshake between a producer and the serial transmitter.
// The producer drives data_in/load_valid; the transmitter answers with load_ready.
interface piso_serial_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: LSB-first on so, one se pulse per bit.
// A one-word hold buffer lets the next word follow the last bit with no gap.
module piso_serial_tx #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    piso_serial_tx_if.slave       bus,
    output logic                  so,
    output logic                  se,
    output logic                  word_done,
    output logic                  busy
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;

    logic se_int;
    logic last;
    logic take;
    logic accept;

    // Bit strobe and last-bit decode come from registers only.
    always_comb begin
        se_int = (state == SHIFT) && (div_cnt == DW'(DIV - 1));
        last   = se_int && (bit_cnt == BW'(WIDTH - 1));
        take   = hold_full && ((state == IDLE) || last);
        accept = bus.load_valid && bus.load_ready;
    end

    assign bus.load_ready = !hold_full && !flush;
    assign so             = (state == SHIFT) ? shreg[0] : 1'b0;
    assign se             = se_int && !flush;
    assign word_done      = last && !flush;
    assign busy           = (state == SHIFT);

    // Hold buffer: filled by an accept, emptied when the shifter takes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (flush) begin
            hold_full <= 1'b0;
        end else if (take) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_reg  <= bus.data_in;
            hold_full <= 1'b1;
        end
    end

    // Shifter and bit/divider counters; reload from hold on the last bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (flush) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hold_full) begin
                        state   <= SHIFT;
                        shreg   <= hold_reg;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (se_int) begin
                        div_cnt <= '0;
                        if (last) begin
                            bit_cnt <= '0;
                            if (hold_full) begin
                                shreg <= hold_reg;
                            end else begin
                                shreg <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: DIV=1 and DIV=3 instances, a bit-queue model
// checked every cycle, and directed scenarios with literal expectations.
module tb_piso_serial_tx;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] fl;
    logic [1:0] vld;
    logic [3:0] din [2];
    logic [1:0] rdy;
    logic [1:0] so_v;
    logic [1:0] se_v;
    logic [1:0] wd_v;
    logic [1:0] bz_v;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit       m_act [2];
    bit       m_hf  [2];
    logic [3:0] m_hw [2];
    logic [3:0] m_cw [2];
    int       m_nb  [2];
    int       m_ph  [2];
    logic [3:0] rx  [2];

    int       se_cnt   [2];
    int       se_first [2];
    int       se_last  [2];
    int       acc_cyc  [2];
    logic [3:0] rxlog [2][64];
    int       rxn      [2];

    always #5 clk = ~clk;

    // Cycle counter, stepped on each rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : u
        piso_serial_tx_if #(.WIDTH(W)) bus ();
        assign bus.data_in    = din[g];
        assign bus.load_valid = vld[g];
        assign rdy[g]         = bus.load_ready;
        piso_serial_tx #(.WIDTH(W), .DIV(g == 0 ? 1 : 3)) dut (
            .clk       (clk),
            .rstn      (rstn),
            .flush     (fl[g]),
            .bus       (bus),
            .so        (so_v[g]),
            .se        (se_v[g]),
            .word_done (wd_v[g]),
            .busy      (bz_v[g])
        );
    end

    task automatic chk(string n, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at cyc %0d", n, a, e, cyc);
        end
    endtask

    // Model: per instance, a current word with bits left, a phase counter
    // and a one-word hold; compared against the DUT mid-cycle.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int d;
            bit ese, eso, edn, ebz, erdy, acc;
            d = (g == 0) ? 1 : 3;
            if (!rstn) begin
                m_act[g] = 0;
                m_hf[g]  = 0;
                m_nb[g]  = 0;
                m_ph[g]  = 0;
                m_cw[g]  = '0;
                rx[g]    = '0;
            end
            ese  = m_act[g] && (m_ph[g] == d - 1) && !fl[g];
            eso  = m_act[g] ? m_cw[g][W - m_nb[g]] : 1'b0;
            edn  = ese && (m_nb[g] == 1);
            ebz  = m_act[g];
            erdy = !m_hf[g] && !fl[g];
            chk($sformatf("so%0d", g), so_v[g], eso);
            chk($sformatf("se%0d", g), se_v[g], ese);
            chk($sformatf("word_done%0d", g), wd_v[g], edn);
            chk($sformatf("busy%0d", g), bz_v[g], ebz);
            chk($sformatf("load_ready%0d", g), rdy[g], erdy);
            if (se_v[g]) begin
                rx[g] = {so_v[g], rx[g][3:1]};
                if (se_cnt[g] == 0) se_first[g] = cyc;
                se_last[g] = cyc;
                se_cnt[g]++;
            end
            if (wd_v[g]) begin
                chk($sformatf("rxword%0d", g), rx[g], m_cw[g]);
                if (rxn[g] < 64) rxlog[g][rxn[g]] = rx[g];
                rxn[g]++;
            end
            if (rstn) begin
                if (fl[g]) begin
                    m_act[g] = 0;
                    m_hf[g]  = 0;
                    m_nb[g]  = 0;
                    m_ph[g]  = 0;
                end else begin
                    acc = vld[g] && erdy;
                    if (m_act[g]) begin
                        if (m_ph[g] == d - 1) begin
                            m_ph[g] = 0;
                            m_nb[g]--;
                            if (m_nb[g] == 0) begin
                                if (m_hf[g]) begin
                                    m_cw[g] = m_hw[g];
                                    m_nb[g] = W;
                                    m_hf[g] = 0;
                                end else begin
                                    m_act[g] = 0;
                                end
                            end
                        end else begin
                            m_ph[g]++;
                        end
                    end else if (m_hf[g]) begin
                        m_cw[g]  = m_hw[g];
                        m_nb[g]  = W;
                        m_ph[g]  = 0;
                        m_act[g] = 1;
                        m_hf[g]  = 0;
                    end
                    if (acc) begin
                        m_hw[g] = din[g];
                        m_hf[g] = 1;
                    end
                end
            end
        end
    end

    task automatic waitc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(int g, logic [3:0] w);
        bit ok;
        ok     = 0;
        din[g] = w;
        vld[g] = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = rdy[g];
            @(posedge clk);
            #1;
        end
        vld[g]     = 1'b0;
        acc_cyc[g] = cyc;
        chk($sformatf("accept%0d", g), ok, 1);
    endtask

    initial begin
        int base;
        int i;
        rstn   = 1'b0;
        fl     = '0;
        vld    = '0;
        din[0] = '0;
        din[1] = '0;
        for (int g = 0; g < 2; g++) begin
            se_cnt[g] = 0;
            rxn[g]    = 0;
        end
        waitc(3);
        chk("rst_ready", rdy[0], 1);
        chk("rst_so", so_v[0], 0);
        chk("rst_se", se_v[0], 0);
        chk("rst_busy", bz_v[0], 0);
        chk("rst_done", wd_v[0], 0);
        rstn = 1'b1;
        waitc(2);

        se_cnt[0] = 0;
        send(0, 4'b1011);
        waitc(8);
        chk("t1_se_count", se_cnt[0], 4);
        chk("t1_latency", se_first[0] - acc_cyc[0], 1);
        chk("t1_contig", se_last[0] - se_first[0], 3);
        chk("t1_word", rxlog[0][rxn[0] - 1], 4'hB);
        chk("t1_busy_low", bz_v[0], 0);

        se_cnt[1] = 0;
        send(1, 4'hC);
        waitc(16);
        chk("d3_se_count", se_cnt[1], 4);
        chk("d3_latency", se_first[1] - acc_cyc[1], 3);
        chk("d3_span", se_last[1] - se_first[1], 9);
        chk("d3_word", rxlog[1][rxn[1] - 1], 4'hC);

        base      = rxn[0];
        se_cnt[0] = 0;
        send(0, 4'h5);
        send(0, 4'hA);
        chk("b2b_ready_low", rdy[0], 0);
        waitc(12);
        chk("b2b_se_count", se_cnt[0], 8);
        chk("b2b_contig", se_last[0] - se_first[0], 7);
        chk("b2b_words", rxn[0] - base, 2);
        chk("b2b_w0", rxlog[0][base], 4'h5);
        chk("b2b_w1", rxlog[0][base + 1], 4'hA);

        base = rxn[0];
        send(0, 4'h3);
        send(0, 4'hE);
        send(0, 4'h7);
        waitc(20);
        chk("bp_words", rxn[0] - base, 3);
        chk("bp_w0", rxlog[0][base], 4'h3);
        chk("bp_w1", rxlog[0][base + 1], 4'hE);
        chk("bp_w2", rxlog[0][base + 2], 4'h7);

        base      = rxn[0];
        se_cnt[0] = 0;
        send(0, 4'h9);
        i = 0;
        while (se_cnt[0] < 2 && i < 30) begin
            @(posedge clk);
            i++;
        end
        chk("rst_mid_bits", se_cnt[0], 2);
        #1;
        rstn = 1'b0;
        #1;
        chk("rstmid_so", so_v[0], 0);
        chk("rstmid_se", se_v[0], 0);
        chk("rstmid_busy", bz_v[0], 0);
        chk("rstmid_done", wd_v[0], 0);
        chk("rstmid_ready", rdy[0], 1);
        waitc(2);
        rstn = 1'b1;
        waitc(2);
        chk("rstmid_no_word", rxn[0] - base, 0);
        send(0, 4'h6);
        waitc(8);
        chk("rst_new_words", rxn[0] - base, 1);
        chk("rst_new_word", rxlog[0][rxn[0] - 1], 4'h6);

        base = rxn[0];
        send(0, 4'h1);
        send(0, 4'h8);
        fl[0] = 1'b1;
        #1;
        chk("fl_se", se_v[0], 0);
        chk("fl_done", wd_v[0], 0);
        waitc(1);
        fl[0] = 1'b0;
        #1;
        chk("fl_busy", bz_v[0], 0);
        chk("fl_ready", rdy[0], 1);
        chk("fl_se_after", se_v[0], 0);
        waitc(12);
        chk("fl_no_words", rxn[0] - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
